// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Time-multiplexed driver for an 8-digit common-anode 7-segment
//             display. Latches digit data once per frame, decodes hex to
//             active-low segments and scans one digit per dwell, with a short
//             all-dark window at the start of every dwell against ghosting.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int CLK_DIV      = 100000,   // clock cycles per digit dwell (>= 2)
    parameter int BLANK_CYCLES = 16        // dark cycles at dwell start (1..CLK_DIV-1)
) (
    input  logic        clk100mhz,
    input  logic        reset,             // asynchronous, active-low
    input  logic [31:0] digits,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp,
    output logic [7:0]  anodes,
    output logic [7:0]  cathodes,
    output logic        frame_start
);

    localparam int            PW        = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PCNT_MAX  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYCLES);

    // Hex to active-low segment pattern, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7(input logic [3:0] hex);
        logic [6:0] s;
        case (hex)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [PW-1:0] pcnt_q,        pcnt_d;
    logic [2:0]    idx_q,         idx_d;
    logic [31:0]   sh_dig_q,      sh_dig_d;
    logic [7:0]    sh_en_q,       sh_en_d;
    logic [7:0]    sh_dp_q,       sh_dp_d;
    logic [7:0]    anodes_q,      anodes_d;
    logic [7:0]    cathodes_q,    cathodes_d;
    logic          frame_start_q, frame_start_d;

    logic          w_latch;
    logic [3:0]    w_cur_hex;

    // Next-state: dwell/digit counters, frame latch and registered outputs
    always_comb begin
        w_latch       = (pcnt_q == '0) && (idx_q == 3'd0);
        w_cur_hex     = sh_dig_q[{idx_q, 2'b00} +: 4];

        pcnt_d        = pcnt_q + PW'(1);
        idx_d         = idx_q;
        if (pcnt_q == PCNT_MAX) begin
            pcnt_d = '0;
            idx_d  = idx_q + 3'd1;
        end

        // Shadow registers only change at the frame boundary, so a frame
        // never mixes old and new data.
        sh_dig_d      = sh_dig_q;
        sh_en_d       = sh_en_q;
        sh_dp_d       = sh_dp_q;
        if (w_latch) begin
            sh_dig_d = digits;
            sh_en_d  = digit_en;
            sh_dp_d  = dp;
        end

        // Outputs come from the pre-edge counters, so the dark window covers
        // the first BLANK_CYCLES output cycles of every dwell.
        frame_start_d = w_latch;
        anodes_d      = 8'hFF;
        cathodes_d    = 8'hFF;
        if ((pcnt_q >= BLANK_LIM) && sh_en_q[idx_q]) begin
            anodes_d   = ~(8'h01 << idx_q);
            cathodes_d = {~sh_dp_q[idx_q], seg7(w_cur_hex)};
        end
    end

    // State register with asynchronous active-low clear
    always_ff @(posedge clk100mhz or negedge reset) begin
        if (!reset) begin
            pcnt_q        <= '0;
            idx_q         <= 3'd0;
            sh_dig_q      <= 32'd0;
            sh_en_q       <= 8'd0;
            sh_dp_q       <= 8'd0;
            anodes_q      <= 8'hFF;
            cathodes_q    <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            pcnt_q        <= pcnt_d;
            idx_q         <= idx_d;
            sh_dig_q      <= sh_dig_d;
            sh_en_q       <= sh_en_d;
            sh_dp_q       <= sh_dp_d;
            anodes_q      <= anodes_d;
            cathodes_q    <= cathodes_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign anodes      = anodes_q;
    assign cathodes    = cathodes_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Purpose  : Self-checking bench for seg7_scan_driver (CLK_DIV=8,
//             BLANK_CYCLES=2): decode table, full-frame sequences, frame
//             latching, async reset and randomized traffic against a
//             frame-position reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int CD = 8;
    localparam int BL = 2;
    localparam int FR = 8 * CD;

    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [7:0] AN_E  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    localparam logic [7:0] CAT_E [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] digits = 32'd0;
    logic [7:0]  digit_en = 8'hFF;
    logic [7:0]  dp = 8'h00;
    logic [7:0]  anodes;
    logic [7:0]  cathodes;
    logic        frame_start;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    seg7_scan_driver #(.CLK_DIV(CD), .BLANK_CYCLES(BL)) dut (
        .clk100mhz  (clk),
        .reset      (reset),
        .digits     (digits),
        .digit_en   (digit_en),
        .dp         (dp),
        .anodes     (anodes),
        .cathodes   (cathodes),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: position in the frame is just the cycle count since
    // reset release modulo 64; data is captured whenever that position is 0.
    int          m_t;
    int          m_pos, m_i, m_p;
    logic [31:0] m_dig;
    logic [7:0]  m_en, m_dp;
    logic [7:0]  e_an, e_cat;
    logic        e_fs;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_t   <= 0;
            m_dig <= 32'd0;
            m_en  <= 8'd0;
            m_dp  <= 8'd0;
            e_an  <= 8'hFF;
            e_cat <= 8'hFF;
            e_fs  <= 1'b0;
        end else begin
            m_pos = m_t % FR;
            m_i   = m_pos / CD;
            m_p   = m_pos % CD;
            e_fs <= (m_pos == 0);
            if (m_p >= BL && m_en[m_i]) begin
                e_an  <= ~(8'h01 << m_i);
                e_cat <= {~m_dp[m_i], SEG[m_dig[4*m_i +: 4]]};
            end else begin
                e_an  <= 8'hFF;
                e_cat <= 8'hFF;
            end
            if (m_pos == 0) begin
                m_dig <= digits;
                m_en  <= digit_en;
                m_dp  <= dp;
            end
            m_t <= m_t + 1;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en)
            check("stream", {15'd0, anodes, cathodes, frame_start}, {15'd0, e_an, e_cat, e_fs});
    end

    task automatic wait_fs();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < FR + 4; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("frame_start_timeout", 32'd0, 32'd1);
    endtask

    // Check one full frame of 76543210 against the literal table, starting at
    // the cycle frame_start is seen; digits with en bit clear stay dark.
    task automatic check_frame(input logic [7:0] en);
        wait_fs();
        for (int j = 0; j < FR; j++) begin
            if (j > 0) @(negedge clk);
            if ((j % CD) < BL || !en[j / CD]) begin
                check("frame_an", {24'd0, anodes}, 32'h0000_00FF);
                check("frame_cat", {24'd0, cathodes}, 32'h0000_00FF);
            end else begin
                check("frame_an", {24'd0, anodes}, {24'd0, AN_E[j / CD]});
                check("frame_cat", {24'd0, cathodes}, {24'd0, CAT_E[j / CD]});
            end
            check("frame_fs", {31'd0, frame_start}, {31'd0, (j == 0)});
        end
    endtask

    typedef struct {
        logic [3:0] hex;
        logic       dpb;
        logic [7:0] exp_cat;
    } vec_t;

    vec_t tbl [19];

    initial begin
        tbl[0]  = '{4'h0, 1'b0, 8'hC0};
        tbl[1]  = '{4'h1, 1'b0, 8'hF9};
        tbl[2]  = '{4'h2, 1'b0, 8'hA4};
        tbl[3]  = '{4'h3, 1'b0, 8'hB0};
        tbl[4]  = '{4'h4, 1'b0, 8'h99};
        tbl[5]  = '{4'h5, 1'b0, 8'h92};
        tbl[6]  = '{4'h6, 1'b0, 8'h82};
        tbl[7]  = '{4'h7, 1'b0, 8'hF8};
        tbl[8]  = '{4'h8, 1'b0, 8'h80};
        tbl[9]  = '{4'h9, 1'b0, 8'h90};
        tbl[10] = '{4'hA, 1'b0, 8'h88};
        tbl[11] = '{4'hB, 1'b0, 8'h83};
        tbl[12] = '{4'hC, 1'b0, 8'hC6};
        tbl[13] = '{4'hD, 1'b0, 8'hA1};
        tbl[14] = '{4'hE, 1'b0, 8'h86};
        tbl[15] = '{4'hF, 1'b0, 8'h8E};
        tbl[16] = '{4'h8, 1'b1, 8'h00};
        tbl[17] = '{4'h0, 1'b1, 8'h40};
        tbl[18] = '{4'hA, 1'b1, 8'h08};

        // Reset: held low for 5 cycles, outputs dark throughout
        #3 reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("reset_an", {24'd0, anodes}, 32'h0000_00FF);
            check("reset_cat", {24'd0, cathodes}, 32'h0000_00FF);
            check("reset_fs", {31'd0, frame_start}, 32'd0);
        end
        chk_en = 1'b1;
        reset  = 1'b1;
        @(negedge clk);
        check("rel1_fs", {31'd0, frame_start}, 32'd1);
        check("rel1_an", {24'd0, anodes}, 32'h0000_00FF);
        @(negedge clk);
        check("rel2_fs", {31'd0, frame_start}, 32'd0);
        check("rel2_cat", {24'd0, cathodes}, 32'h0000_00FF);

        // Decode table: all digits show the same value, check digit 0
        foreach (tbl[n]) begin
            bit found;
            digits   = {8{tbl[n].hex}};
            dp       = {8{tbl[n].dpb}};
            digit_en = 8'hFF;
            repeat (FR) @(negedge clk);
            found = 1'b0;
            for (int k = 0; k < FR + 8; k++) begin
                @(negedge clk);
                if (anodes === 8'hFE) begin
                    found = 1'b1;
                    break;
                end
            end
            if (found) check($sformatf("decode_%h_dp%0d", tbl[n].hex, tbl[n].dpb),
                             {24'd0, cathodes}, {24'd0, tbl[n].exp_cat});
            else       check("decode_timeout", 32'd0, 32'd1);
        end

        // Full frame with 76543210, then with only digits 0-3 enabled
        digits   = 32'h7654_3210;
        dp       = 8'h00;
        digit_en = 8'hFF;
        wait_fs();
        check_frame(8'hFF);
        digit_en = 8'h0F;
        wait_fs();
        check_frame(8'h0F);

        // Mid-frame data change only shows from the next frame
        digit_en = 8'hFF;
        wait_fs();
        wait_fs();
        repeat (17) @(negedge clk);
        digits = 32'hFFFF_FFFF;
        repeat (4) @(negedge clk);
        check("midframe_old_d2", {24'd0, cathodes}, 32'h0000_00A4);
        wait_fs();
        repeat (BL) @(negedge clk);
        check("midframe_new_d0", {24'd0, cathodes}, 32'h0000_008E);

        // Async reset while a digit is lit
        digits = 32'h7654_3210;
        wait_fs();
        wait_fs();
        repeat (12) @(negedge clk);
        check("pre_rst_an", {24'd0, anodes}, 32'h0000_00FD);
        #2 reset = 1'b0;
        #1;
        check("async_rst_an", {24'd0, anodes}, 32'h0000_00FF);
        check("async_rst_cat", {24'd0, cathodes}, 32'h0000_00FF);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("restart_fs", {31'd0, frame_start}, 32'd1);
        repeat (BL) @(negedge clk);
        check("restart_an", {24'd0, anodes}, 32'h0000_00FE);

        // Randomized traffic checked by the model every cycle
        for (int k = 0; k < 30 * FR; k++) begin
            @(negedge clk);
            if ($urandom_range(19, 0) == 0) begin
                digits   = $urandom;
                digit_en = 8'($urandom);
                dp       = 8'($urandom);
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
